icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 INDEX_BITS, 6, number of index bits; the cache holds 2^INDEX_BITS lines of one 32-bit word each.
REQ-002 ADDR_BITS, 18, number of meaningful address bits; bits above it are ignored.
REQ-003 clk  in  1  system clock; the one clock, all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 rdy  in  1  global ready; while low, all state and outputs are frozen.
REQ-006 clear  in  1  pipeline flush from the reorder buffer on mispredict.
REQ-007 fetch_valid  in  1  fetch request; held high with a stable fetch_addr until inst_ready pulses.
REQ-008 fetch_addr  in  32  instruction byte address, word aligned.
REQ-009 inst_ready  out  1  one-cycle pulse: inst is valid for the accepted request.
REQ-010 inst  out  32  instruction word.
REQ-011 mem_valid  out  1  refill request to the data_cache instruction port.
REQ-012 mem_addr  out  32  refill word address.
REQ-013 mem_ready  in  1  one-cycle pulse: mem_inst is valid.
REQ-014 mem_inst  in  32  refill data.

Function
REQ-015 Address split: offset = addr[1:0] (ignored), index = addr[INDEX_BITS+1:2], tag = addr[ADDR_BITS-1:INDEX_BITS+2].
REQ-016 Per-line storage: valid bit, tag and 32-bit data; direct mapped, no replacement choice.
REQ-017 FSM states: IDLE, MISS, RESP.
REQ-018 IDLE with fetch_valid and not clear, and a hit: register the data; inst_ready=1 on the next cycle; stay in IDLE; hit latency is exactly 1 cycle.
REQ-019 While the inst_ready pulse of a hit is high, no new request is accepted; the FSM stays idle that cycle, so back-to-back hits complete every 2 cycles.
REQ-020 IDLE with fetch_valid and not clear, and a miss: latch the request address; enter MISS.
REQ-021 MISS: mem_valid=1 and mem_addr = {latched addr[31:2], 2'b00}, held stable until mem_ready.
REQ-022 MISS on mem_ready: write valid, tag and mem_inst into the indexed line; drive inst = mem_inst with inst_ready=1 on the next cycle via RESP; RESP returns to IDLE after one cycle.
REQ-023 clear in any state: drop the pending request; mem_valid=0 and inst_ready=0 on the next cycle; enter IDLE; no response is ever issued for the dropped request.
REQ-024 clear coincident with mem_ready: the line is still written (the data is correct); no inst_ready is issued.
REQ-025 clear does not invalidate lines.
REQ-026 clear coincident with a new fetch_valid: the request is not accepted; fetch re-presents it after clear.
REQ-027 A request whose index matches but whose tag differs is a miss and overwrites the line.
REQ-028 mem_valid deasserts in the cycle after mem_ready is sampled; at most one outstanding refill exists.
REQ-029 rdy low: no FSM transition, no array write, mem_ready ignored; the data_cache also stalls under rdy.
REQ-030 Self-modifying code is unsupported; stores do not snoop this cache.

Reset
REQ-031 With rst high at a clock edge: all valid bits clear, state=IDLE, inst_ready=0, inst=0, mem_valid=0, mem_addr=0.
REQ-032 Reset mid-refill abandons the refill, with no array write even if mem_ready is high that cycle.
REQ-033 Tag and data arrays need no reset.
REQ-034 rst has priority over clear and rdy.

Structure
REQ-035 The index and tag widths and the state encoding are defined in const.v alongside the existing shared constants.
REQ-036 The tag/data/valid store is a sub-module icache_array with one read port (combinational read) and one write port.
REQ-037 The array is instantiated once inside icache.
REQ-038 icache is instantiated in cpu between fetch and data_cache.

Verification
REQ-039 Cold miss: after rst, fetch 0x00000010 -> mem_valid with mem_addr 0x10; mem_ready with 0x00A00093 -> inst_ready one cycle later with inst 0x00A00093.
REQ-040 Hit: refetch 0x10 -> inst_ready exactly 1 cycle after acceptance, with no mem_valid.
REQ-041 Conflict: fetch 0x10, then 0x110 (same index, different tag) -> second access misses and refills; fetching 0x10 again misses.
REQ-042 Flush: clear while in MISS before mem_ready -> no inst_ready; the next fetch of 0x20 is served correctly.
REQ-043 Flush with mem_ready in the same cycle -> no inst_ready; a later fetch of that address hits.
REQ-044 Stall: rdy low for 5 cycles during MISS, with mem_ready pulsed while rdy is low -> state and mem_addr are unchanged, and there is no response until rdy is high and mem_ready is re-pulsed.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared widths, FSM encoding and address helpers for the instruction cache.
package icache_pkg;

    localparam int unsigned ICACHE_INDEX_BITS = 6;
    localparam int unsigned ICACHE_ADDR_BITS  = 18;
    localparam int unsigned ICACHE_WORD_BITS  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MISS = 2'd1,
        ST_RESP = 2'd2
    } icache_state_e;

    // Word-aligned refill address for a fetch byte address.
    function automatic logic [ICACHE_WORD_BITS-1:0] word_align(input logic [ICACHE_WORD_BITS-1:0] addr);
        return {addr[ICACHE_WORD_BITS-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line store: valid/tag/data, one combinational read port, one write port.
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int unsigned TAG_BITS   = ICACHE_ADDR_BITS - ICACHE_INDEX_BITS - 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [INDEX_BITS-1:0]       rd_idx_i,
    output logic                        rd_valid_c_o,
    output logic [TAG_BITS-1:0]         rd_tag_c_o,
    output logic [ICACHE_WORD_BITS-1:0] rd_data_c_o,
    input  logic                        wr_en_i,
    input  logic [INDEX_BITS-1:0]       wr_idx_i,
    input  logic [TAG_BITS-1:0]         wr_tag_i,
    input  logic [ICACHE_WORD_BITS-1:0] wr_data_i
);

    localparam int unsigned LINES = 2 ** INDEX_BITS;

    logic [LINES-1:0]            valid_q;
    logic [TAG_BITS-1:0]         tag_q  [LINES];
    logic [ICACHE_WORD_BITS-1:0] data_q [LINES];

    // Valid bits are the only reset state; a write always marks the line valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data storage, unreset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_c_o = valid_q[rd_idx_i];
    assign rd_tag_c_o   = tag_q[rd_idx_i];
    assign rd_data_c_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped single-word-line instruction cache between fetch and the data cache.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int unsigned ADDR_BITS  = ICACHE_ADDR_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    output logic        inst_ready,
    output logic [31:0] inst,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_inst
);

    localparam int unsigned TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

    icache_state_e state_q, state_d;
    logic          inst_ready_q, inst_ready_d;
    logic [31:0]   inst_q, inst_d;
    logic          mem_valid_q, mem_valid_d;
    logic [31:0]   mem_addr_q, mem_addr_d;

    logic                  arr_we_c;
    logic                  rd_valid_c;
    logic [TAG_BITS-1:0]   rd_tag_c;
    logic [31:0]           rd_data_c;
    logic [INDEX_BITS-1:0] fetch_idx_c;
    logic [TAG_BITS-1:0]   fetch_tag_c;
    logic [INDEX_BITS-1:0] req_idx_c;
    logic [TAG_BITS-1:0]   req_tag_c;
    logic                  hit_c;
    logic                  unused_c;

    assign fetch_idx_c = fetch_addr[INDEX_BITS+1:2];
    assign fetch_tag_c = fetch_addr[ADDR_BITS-1:INDEX_BITS+2];
    assign req_idx_c   = mem_addr_q[INDEX_BITS+1:2];
    assign req_tag_c   = mem_addr_q[ADDR_BITS-1:INDEX_BITS+2];
    assign hit_c       = rd_valid_c && (rd_tag_c == fetch_tag_c);
    assign unused_c    = ^{fetch_addr[1:0], mem_addr_q[1:0]};

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .rd_idx_i     (fetch_idx_c),
        .rd_valid_c_o (rd_valid_c),
        .rd_tag_c_o   (rd_tag_c),
        .rd_data_c_o  (rd_data_c),
        .wr_en_i      (arr_we_c && !rst),
        .wr_idx_i     (req_idx_c),
        .wr_tag_i     (req_tag_c),
        .wr_data_i    (mem_inst)
    );

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            inst_ready_q <= 1'b0;
            inst_q       <= '0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            inst_ready_q <= inst_ready_d;
            inst_q       <= inst_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Next-state and output logic; everything holds while rdy is low.
    always_comb begin
        state_d      = state_q;
        inst_ready_d = inst_ready_q;
        inst_d       = inst_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        arr_we_c     = 1'b0;

        if (rdy) begin
            inst_ready_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // No acceptance during a hit's response pulse.
                    if (fetch_valid && !clear && !inst_ready_q) begin
                        if (hit_c) begin
                            inst_d       = rd_data_c;
                            inst_ready_d = 1'b1;
                        end else begin
                            mem_addr_d  = word_align(fetch_addr);
                            mem_valid_d = 1'b1;
                            state_d     = ST_MISS;
                        end
                    end
                end
                ST_MISS: begin
                    if (mem_ready) begin
                        // Refill data is good even when flushed, so the line is kept.
                        arr_we_c    = 1'b1;
                        mem_valid_d = 1'b0;
                        if (clear) begin
                            state_d = ST_IDLE;
                        end else begin
                            inst_d       = mem_inst;
                            inst_ready_d = 1'b1;
                            state_d      = ST_RESP;
                        end
                    end else if (clear) begin
                        mem_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                ST_RESP: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d     = ST_IDLE;
                    mem_valid_d = 1'b0;
                end
            endcase
        end
    end

    assign inst_ready = inst_ready_q;
    assign inst       = inst_q;
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed and randomized checks of icache against a line-level reference model.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        inst_ready;
    logic [31:0] inst;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_inst;

    int passed = 0;
    int total  = 0;

    // Reference model: 64 lines, 10-bit tags from address bits [17:8].
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_data  [64];

    icache dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .clear       (clear),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_inst    (mem_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a >> 2) & 32'd63;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return (a >> 8) & 32'd1023;
    endfunction

    // Backing memory contents; only address bits below 18 matter.
    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] w;
        w = (a >> 2) & 32'h0000_FFFF;
        if (w == 32'd4) return 32'h00A0_0093;
        return (w * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    task automatic model_fill(input logic [31:0] a);
        m_valid[idx_of(a)] = 1'b1;
        m_tag[idx_of(a)]   = tag_of(a);
        m_data[idx_of(a)]  = memf(a);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One complete fetch: drive, serve any refill after lat cycles, check the response.
    task automatic do_fetch(input logic [31:0] a, input int lat);
        logic [31:0] exp_data;
        bit          exp_hit;
        exp_hit     = model_hit(a);
        exp_data    = m_data[idx_of(a)];
        fetch_valid = 1'b1;
        fetch_addr  = a;
        @(negedge clk);
        if (exp_hit) begin
            chk("hit_ready", 32'(inst_ready), 32'd1);
            chk("hit_inst", inst, exp_data);
            chk("hit_no_mem", 32'(mem_valid), 32'd0);
        end else begin
            chk("miss_mem_valid", 32'(mem_valid), 32'd1);
            chk("miss_mem_addr", mem_addr, a & 32'hFFFF_FFFC);
            chk("miss_no_ready", 32'(inst_ready), 32'd0);
            repeat (lat) @(negedge clk);
            chk("miss_hold_addr", mem_addr, a & 32'hFFFF_FFFC);
            mem_ready = 1'b1;
            mem_inst  = memf(a);
            @(negedge clk);
            mem_ready = 1'b0;
            mem_inst  = $urandom;
            chk("refill_ready", 32'(inst_ready), 32'd1);
            chk("refill_inst", inst, memf(a));
            chk("refill_mem_drop", 32'(mem_valid), 32'd0);
            model_fill(a);
        end
        fetch_valid = 1'b0;
        @(negedge clk);
        chk("pulse_end", 32'(inst_ready), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        rst         = 1'b1;
        rdy         = 1'b1;
        clear       = 1'b0;
        fetch_valid = 1'b0;
        fetch_addr  = '0;
        mem_ready   = 1'b0;
        mem_inst    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_inst_ready", 32'(inst_ready), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss then hit.
        do_fetch(32'h0000_0010, 2);
        do_fetch(32'h0000_0010, 0);

        // Back-to-back hits with fetch_valid held: one response every 2 cycles.
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0000_0010;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(inst_ready), 32'((i % 2) == 0));
        end
        fetch_valid = 1'b0;
        @(negedge clk);

        // Index conflict: 0x110 evicts 0x10.
        do_fetch(32'h0000_0110, 1);
        do_fetch(32'h0000_0010, 0);

        // Flush during a refill before mem_ready.
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0000_0030;
        @(negedge clk);
        chk("flush_miss_mv", 32'(mem_valid), 32'd1);
        fetch_valid = 1'b0;
        clear       = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("flush_mem_drop", 32'(mem_valid), 32'd0);
        chk("flush_no_ready", 32'(inst_ready), 32'd0);
        @(negedge clk);
        chk("flush_still_quiet", 32'(inst_ready), 32'd0);
        do_fetch(32'h0000_0020, 1);
        do_fetch(32'h0000_0030, 0);

        // Flush coincident with mem_ready: line kept, no response.
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0000_0044;
        @(negedge clk);
        chk("flushrdy_mv", 32'(mem_valid), 32'd1);
        fetch_valid = 1'b0;
        clear       = 1'b1;
        mem_ready   = 1'b1;
        mem_inst    = memf(32'h0000_0044);
        @(negedge clk);
        clear     = 1'b0;
        mem_ready = 1'b0;
        chk("flushrdy_no_ready", 32'(inst_ready), 32'd0);
        chk("flushrdy_mem_drop", 32'(mem_valid), 32'd0);
        model_fill(32'h0000_0044);
        @(negedge clk);
        chk("flushrdy_quiet", 32'(inst_ready), 32'd0);
        do_fetch(32'h0000_0044, 0);

        // Clear coincident with a new fetch: not accepted.
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0000_0020;
        clear       = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clrfetch_no_ready", 32'(inst_ready), 32'd0);
        chk("clrfetch_no_mem", 32'(mem_valid), 32'd0);
        do_fetch(32'h0000_0020, 0);

        // Stall during MISS with an ignored mem_ready pulse.
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0000_0084;
        @(negedge clk);
        chk("stall_mv", 32'(mem_valid), 32'd1);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 1);
            mem_inst  = memf(32'h0000_0084);
            @(negedge clk);
            chk("stall_mv_hold", 32'(mem_valid), 32'd1);
            chk("stall_addr_hold", mem_addr, 32'h0000_0084);
            chk("stall_no_ready", 32'(inst_ready), 32'd0);
        end
        mem_ready = 1'b0;
        rdy       = 1'b1;
        @(negedge clk);
        chk("unstall_waiting", 32'(mem_valid), 32'd1);
        chk("unstall_no_ready", 32'(inst_ready), 32'd0);
        mem_ready = 1'b1;
        mem_inst  = memf(32'h0000_0084);
        @(negedge clk);
        mem_ready = 1'b0;
        chk("unstall_ready", 32'(inst_ready), 32'd1);
        chk("unstall_inst", inst, memf(32'h0000_0084));
        model_fill(32'h0000_0084);
        fetch_valid = 1'b0;
        @(negedge clk);

        // Reset mid-refill: no array write even with mem_ready high.
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0000_0200;
        @(negedge clk);
        chk("rstmid_mv", 32'(mem_valid), 32'd1);
        fetch_valid = 1'b0;
        rst         = 1'b1;
        clear       = 1'b1;
        mem_ready   = 1'b1;
        mem_inst    = memf(32'h0000_0200);
        @(negedge clk);
        rst       = 1'b0;
        clear     = 1'b0;
        mem_ready = 1'b0;
        model_reset();
        chk("rstmid_mem_drop", 32'(mem_valid), 32'd0);
        chk("rstmid_addr", mem_addr, 32'd0);
        chk("rstmid_inst", inst, 32'd0);
        do_fetch(32'h0000_0200, 1);
        do_fetch(32'h0000_0010, 0);

        // Randomized traffic over a small footprint, including ignored high address bits.
        for (int n = 0; n < 60; n++) begin
            a = (32'($urandom_range(0, 3)) << 18) | (32'($urandom_range(0, 3)) << 8)
              | (32'($urandom_range(0, 7)) << 2);
            do_fetch(a, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
